// File: rtl/rf_pkg.sv
// Shared constants for the register-file write arbiter and register file.
// Source indices, the SP register address and the SP reset value live here.
package rf_pkg;

    localparam int         NUM_SRC  = 3;
    localparam logic [1:0] SRC_ALU  = 2'd0;
    localparam logic [1:0] SRC_LD   = 2'd1;
    localparam logic [1:0] SRC_SP   = 2'd2;
    localparam logic [1:0] REG_SP   = 2'b11;
    localparam logic [7:0] SP_RESET = 8'hFF;

    // Round-robin pointer after a grant to src g: the source after g, wrapping 2->0.
    function automatic logic [1:0] next_ptr(input logic [1:0] g);
        return (g == SRC_SP) ? SRC_ALU : g + 2'd1;
    endfunction

    // Isolates the lowest set bit of a 3-bit request vector.
    function automatic logic [2:0] lowest_one(input logic [2:0] v);
        return v & (~v + 3'd1);
    endfunction

endpackage

// File: rtl/rf_wr_arbiter_pick.sv
// rr_pick3: combinational 3-way picker; starved (override) requests win first,
// lowest index among them, else fixed priority or round robin from ptr.
import rf_pkg::*;

module rr_pick3 (
    input  logic [2:0] req,
    input  logic [1:0] ptr,
    input  logic       mode,
    input  logic [2:0] ovr,
    output logic [2:0] gnt
);

    logic [2:0] ovr_req;

    assign ovr_req = ovr & req;

    always_comb begin
        gnt = 3'b000;
        if (ovr_req != 3'b000) begin
            gnt = lowest_one(ovr_req);
        end else if (!mode) begin
            gnt = lowest_one(req);
        end else begin
            case (ptr)
                2'd1:    gnt = req[1] ? 3'b010 : req[2] ? 3'b100 : req[0] ? 3'b001 : 3'b000;
                2'd2:    gnt = req[2] ? 3'b100 : req[0] ? 3'b001 : req[1] ? 3'b010 : 3'b000;
                default: gnt = req[0] ? 3'b001 : req[1] ? 3'b010 : req[2] ? 3'b100 : 3'b000;
            endcase
        end
    end

endmodule

// File: rtl/rf_wr_arbiter.sv
// Shares the register file write port among ALU, load and SP requesters; one grant per cycle,
// ready is combinational from valid, the winning write is registered (strobe one cycle after accept).
import rf_pkg::*;

module rf_wr_arbiter #(
    parameter int DW       = 8,
    parameter int AW       = 2,
    parameter int ARB_MODE = 1,
    parameter int MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          alu_valid,
    output logic          alu_ready,
    input  logic [AW-1:0] alu_addr,
    input  logic [DW-1:0] alu_data,
    input  logic          ld_valid,
    output logic          ld_ready,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_data,
    input  logic          sp_valid,
    output logic          sp_ready,
    input  logic [DW-1:0] sp_data,
    output logic          rf_we,
    output logic [AW-1:0] rf_waddr,
    output logic [DW-1:0] rf_wdata,
    output logic          rf_sp_we,
    output logic [DW-1:0] rf_sp_value,
    input  logic          clr_err,
    output logic          illegal_wr,
    output logic          illegal_src
);

    localparam int            CW      = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_WAIT);

    logic [NUM_SRC-1:0] req;
    logic [NUM_SRC-1:0] gnt;
    logic [NUM_SRC-1:0] ovr;
    logic [1:0]         rr_ptr;
    logic [CW-1:0]      wait_cnt [NUM_SRC];

    logic [1:0]         gnt_idx;
    logic [AW-1:0]      sel_addr;
    logic [DW-1:0]      sel_data;
    logic               xfer;
    logic               reg_src;
    logic               legal_wr;
    logic               bad_wr;
    logic               sp_wr;

    assign req = {sp_valid, ld_valid, alu_valid};

    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            ovr[i] = (MAX_WAIT > 0) && (wait_cnt[i] >= CNT_MAX);
        end
    end

    rr_pick3 u_pick (
        .req  (req),
        .ptr  (rr_ptr),
        .mode (ARB_MODE != 0),
        .ovr  (ovr),
        .gnt  (gnt)
    );

    assign alu_ready = gnt[SRC_ALU];
    assign ld_ready  = gnt[SRC_LD];
    assign sp_ready  = gnt[SRC_SP];

    always_comb begin
        gnt_idx  = SRC_ALU;
        sel_addr = alu_addr;
        sel_data = alu_data;
        if (gnt[SRC_LD]) begin
            gnt_idx  = SRC_LD;
            sel_addr = ld_addr;
            sel_data = ld_data;
        end else if (gnt[SRC_SP]) begin
            gnt_idx  = SRC_SP;
        end
    end

    // R3 is the stack pointer: only the SP unit may write it, other writes are
    // accepted (so the requester never hangs) but dropped and flagged.
    assign xfer     = |gnt;
    assign reg_src  = xfer && (gnt_idx != SRC_SP);
    assign legal_wr = reg_src && (sel_addr != AW'(REG_SP));
    assign bad_wr   = reg_src && (sel_addr == AW'(REG_SP));
    assign sp_wr    = gnt[SRC_SP];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= SRC_ALU;
        end else if (xfer) begin
            rr_ptr <= next_ptr(gnt_idx);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                wait_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (!req[i] || gnt[i]) begin
                    wait_cnt[i] <= '0;
                end else if (wait_cnt[i] < CNT_MAX) begin
                    wait_cnt[i] <= wait_cnt[i] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we       <= 1'b0;
            rf_waddr    <= '0;
            rf_wdata    <= '0;
            rf_sp_we    <= 1'b0;
            rf_sp_value <= DW'(SP_RESET);
        end else begin
            rf_we    <= legal_wr;
            rf_sp_we <= sp_wr;
            if (legal_wr) begin
                rf_waddr <= sel_addr;
                rf_wdata <= sel_data;
            end
            if (sp_wr) begin
                rf_sp_value <= sp_data;
            end
        end
    end

    // A new illegal write takes precedence over a same-cycle clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            illegal_wr  <= 1'b0;
            illegal_src <= 1'b0;
        end else if (bad_wr) begin
            illegal_wr  <= 1'b1;
            illegal_src <= gnt_idx[0];
        end else if (clr_err) begin
            illegal_wr  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Scoreboard bench: stimulus pushes expected register-file writes, a negedge monitor pops and compares.
module tb_rf_wr_arbiter;

    typedef struct packed {
        logic       sp;
        logic [1:0] addr;
        logic [7:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic       alu_valid = 1'b0, ld_valid = 1'b0, sp_valid = 1'b0, clr_err = 1'b0;
    logic [1:0] alu_addr = '0, ld_addr = '0;
    logic [7:0] alu_data = '0, ld_data = '0, sp_data = '0;
    logic       alu_ready, ld_ready, sp_ready, rf_we, rf_sp_we, illegal_wr, illegal_src;
    logic [1:0] rf_waddr;
    logic [7:0] rf_wdata, rf_sp_value;

    logic       f_alu_valid = 1'b0, f_ld_valid = 1'b0, f_sp_valid = 1'b0, f_clr_err = 1'b0;
    logic [1:0] f_alu_addr = '0, f_ld_addr = '0;
    logic [7:0] f_alu_data = '0, f_ld_data = '0, f_sp_data = '0;
    logic       f_alu_ready, f_ld_ready, f_sp_ready, f_rf_we, f_rf_sp_we, f_illegal_wr, f_illegal_src;
    logic [1:0] f_rf_waddr;
    logic [7:0] f_rf_wdata, f_rf_sp_value;

    exp_t rrq[$];
    exp_t fpq[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    rf_wr_arbiter #(.DW(8), .AW(2), .ARB_MODE(1), .MAX_WAIT(4)) u_rr (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
        .sp_valid(sp_valid), .sp_ready(sp_ready), .sp_data(sp_data),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .rf_sp_we(rf_sp_we), .rf_sp_value(rf_sp_value),
        .clr_err(clr_err), .illegal_wr(illegal_wr), .illegal_src(illegal_src)
    );

    rf_wr_arbiter #(.DW(8), .AW(2), .ARB_MODE(0), .MAX_WAIT(4)) u_fp (
        .clk(clk), .rst(rst),
        .alu_valid(f_alu_valid), .alu_ready(f_alu_ready), .alu_addr(f_alu_addr), .alu_data(f_alu_data),
        .ld_valid(f_ld_valid), .ld_ready(f_ld_ready), .ld_addr(f_ld_addr), .ld_data(f_ld_data),
        .sp_valid(f_sp_valid), .sp_ready(f_sp_ready), .sp_data(f_sp_data),
        .rf_we(f_rf_we), .rf_waddr(f_rf_waddr), .rf_wdata(f_rf_wdata),
        .rf_sp_we(f_rf_sp_we), .rf_sp_value(f_rf_sp_value),
        .clr_err(f_clr_err), .illegal_wr(f_illegal_wr), .illegal_src(f_illegal_src)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic mon(input bit f, input logic we, input logic [1:0] wa, input logic [7:0] wd,
                       input logic spwe, input logic [7:0] spv);
        exp_t e;
        int   sz;
        if (we || spwe) begin
            sz = f ? fpq.size() : rrq.size();
            chk(f ? "fp_strobe_expected" : "rr_strobe_expected", 32'(sz > 0), 32'd1);
            chk("strobe_exclusive", 32'(we & spwe), 32'd0);
            if (sz > 0) begin
                if (f) e = fpq.pop_front();
                else   e = rrq.pop_front();
                chk("strobe_kind", 32'(spwe), 32'(e.sp));
                if (e.sp) begin
                    chk("sp_value", 32'(spv), 32'(e.data));
                end else begin
                    chk("waddr", 32'(wa), 32'(e.addr));
                    chk("wdata", 32'(wd), 32'(e.data));
                end
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            mon(1'b0, rf_we, rf_waddr, rf_wdata, rf_sp_we, rf_sp_value);
            mon(1'b1, f_rf_we, f_rf_waddr, f_rf_wdata, f_rf_sp_we, f_rf_sp_value);
        end
    end

    task automatic rr_drive(input int s, input logic v, input logic [1:0] a, input logic [7:0] d);
        case (s)
            0: begin alu_valid = v; alu_addr = a; alu_data = d; end
            1: begin ld_valid = v; ld_addr = a; ld_data = d; end
            default: begin sp_valid = v; sp_data = d; end
        endcase
    endtask

    // One lone request: ready must rise for it alone; starts and ends at posedge+1.
    task automatic single(input int s, input logic [1:0] a, input logic [7:0] d, input bit push);
        exp_t e;
        rr_drive(s, 1'b1, a, d);
        @(negedge clk);
        chk("single_ready", 32'({sp_ready, ld_ready, alu_ready}), 32'd1 << s);
        if (push) begin
            e.sp = (s == 2); e.addr = a; e.data = d;
            rrq.push_back(e);
        end
        @(posedge clk); #1;
        rr_drive(s, 1'b0, a, d);
    endtask

    function automatic logic [1:0] vaddr(input int s, input int i);
        return 2'((s + i) % 3);
    endfunction

    function automatic logic [7:0] vdata(input logic [7:0] base, input int s, input int i);
        return base + 8'(s * 16 + i);
    endfunction

    // All sources keep requesting until their share of ord (2 bits per grant, first in LSBs) is served.
    task automatic run_grants(input int n, input logic [11:0] ord, input logic [7:0] base);
        int   need [3];
        int   done [3];
        int   s;
        exp_t e;
        for (int j = 0; j < 3; j++) begin need[j] = 0; done[j] = 0; end
        for (int k = 0; k < n; k++) need[ord[2*k +: 2]]++;
        for (int k = 0; k < n; k++) begin
            for (int j = 0; j < 3; j++)
                rr_drive(j, done[j] < need[j], vaddr(j, done[j]), vdata(base, j, done[j]));
            @(negedge clk);
            s = int'(ord[2*k +: 2]);
            chk("rr_grant", 32'({sp_ready, ld_ready, alu_ready}), 32'd1 << s);
            e.sp = (s == 2); e.addr = vaddr(s, done[s]); e.data = vdata(base, s, done[s]);
            rrq.push_back(e);
            done[s]++;
            @(posedge clk); #1;
        end
        for (int j = 0; j < 3; j++) rr_drive(j, 1'b0, 2'd0, 8'd0);
    endtask

    initial begin
        int   s;
        exp_t e;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_rf_we", 32'(rf_we), 32'd0);
            chk("idle_rf_sp_we", 32'(rf_sp_we), 32'd0);
            chk("idle_sp_value", 32'(rf_sp_value), 32'hFF);
            chk("idle_illegal", 32'(illegal_wr), 32'd0);
        end

        // Fixed priority: SP starves behind a constant ALU stream until its override fires.
        @(posedge clk); #1;
        f_alu_valid = 1'b1; f_alu_addr = 2'd1; f_alu_data = 8'hA0;
        f_sp_valid = 1'b1; f_sp_data = 8'h5E;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            s = (k == 4) ? 2 : 0;
            chk("fp_grant", 32'({f_sp_ready, f_ld_ready, f_alu_ready}), 32'd1 << s);
            e.sp = (s == 2); e.addr = (s == 2) ? 2'd0 : 2'd1; e.data = (s == 2) ? 8'h5E : f_alu_data;
            fpq.push_back(e);
            @(posedge clk); #1;
            if (s == 2) f_sp_valid = 1'b0;
            else        f_alu_data = f_alu_data + 8'd1;
        end
        f_alu_valid = 1'b0;

        // Lone requests walk the RR pointer 0 -> 1 -> 2 -> 0.
        single(0, 2'd1, 8'h5A, 1'b1);
        single(1, 2'd2, 8'h3C, 1'b1);
        single(2, 2'd0, 8'h11, 1'b1);
        run_grants(6, {2'd2, 2'd1, 2'd0, 2'd2, 2'd1, 2'd0}, 8'h40);
        repeat (2) @(negedge clk);
        chk("sp_value_hold", 32'(rf_sp_value), 32'h61);
        chk("wdata_hold", 32'(rf_wdata), 32'h51);

        // Load write to R3: accepted, dropped, flagged; then clear alone.
        @(posedge clk); #1;
        single(1, 2'd3, 8'h77, 1'b0);
        @(negedge clk);
        chk("illegal_set", 32'(illegal_wr), 32'd1);
        chk("illegal_src_ld", 32'(illegal_src), 32'd1);
        chk("illegal_no_wdata", 32'(rf_wdata), 32'h51);
        @(posedge clk); #1 clr_err = 1'b1;
        @(posedge clk); #1 clr_err = 1'b0;
        @(negedge clk);
        chk("illegal_cleared", 32'(illegal_wr), 32'd0);

        // ALU write to R3 with clr_err in the same cycle: set wins.
        @(posedge clk); #1 clr_err = 1'b1;
        single(0, 2'd3, 8'h99, 1'b0);
        clr_err = 1'b0;
        @(negedge clk);
        chk("illegal_set_wins", 32'(illegal_wr), 32'd1);
        chk("illegal_src_alu", 32'(illegal_src), 32'd0);

        // Reset one cycle after an SP accept discards the pending SP write.
        @(posedge clk); #1;
        single(2, 2'd0, 8'h42, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_sp_we", 32'(rf_sp_we), 32'd0);
        chk("rst_sp_value", 32'(rf_sp_value), 32'hFF);
        chk("rst_illegal", 32'(illegal_wr), 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        // Move the pointer to 1, reset, and expect the ALU to win first again.
        single(0, 2'd2, 8'h66, 1'b1);
        @(negedge clk);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        run_grants(3, {6'd0, 2'd2, 2'd1, 2'd0}, 8'h80);

        repeat (3) @(negedge clk);
        chk("rr_queue_drained", 32'(rrq.size()), 32'd0);
        chk("fp_queue_drained", 32'(fpq.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
